audio_sample_sched: RTL and testbench

// Sample scheduler in front of the I2S serializer. Buffers stereo frames from two

---
 rtl/audio_sample_sched.sv | 86 ++++++++
 tb/tb_audio_sample_sched.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/audio_sample_sched.sv
// audio_sample_sched: two-source stereo frame FIFO feeding the I2S serializer with prefill, drain-on-switch and underrun handling
module audio_sample_sched #(
    parameter int DEPTH     = 8,
    parameter int PREFILL   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk_74a,
    input  logic                       reset_n,
    input  logic                       src0_valid,
    output logic                       src0_ready,
    input  logic [15:0]                src0_l,
    input  logic [15:0]                src0_r,
    input  logic                       src1_valid,
    output logic                       src1_ready,
    input  logic [15:0]                src1_l,
    input  logic [15:0]                src1_r,
    input  logic                       src_sel,
    input  logic                       frame_req,
    output logic [15:0]                out_l,
    output logic [15:0]                out_r,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       active_sel,
    output logic [CNT_WIDTH-1:0]       underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PF   = (AW+1)'(PREFILL);
    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0] level_nx;
    logic [31:0] act_data;
    logic act_valid, act_ready, push, pop, underrun, active_nx;
    always_comb begin
        act_valid  = active_sel ? src1_valid : src0_valid;
        act_data   = active_sel ? {src1_l, src1_r} : {src0_l, src0_r};
        act_ready  = (level != FULL) && (state != DRAIN);
        src0_ready = active_sel ? 1'b1 : act_ready;
        src1_ready = active_sel ? act_ready : 1'b1;
        push       = act_valid && act_ready;
        pop        = frame_req && (state != FILL) && (level != '0);
        underrun   = frame_req && (state == RUN) && (level == '0);
        level_nx   = level + (AW+1)'(push) - (AW+1)'(pop);
        state_nx   = state;
        active_nx  = active_sel;
        if (state != DRAIN && src_sel != active_sel)
            state_nx = DRAIN;
        else if (state == DRAIN && level_nx == '0) begin
            state_nx  = FILL;
            active_nx = src_sel;
        end else if (state == FILL && level >= PF)
            state_nx = RUN;
        else if (underrun)
            state_nx = FILL;
    end
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FILL;
            active_sel   <= 1'b0;
            level        <= '0;
            head         <= '0;
            tail         <= '0;
            out_l        <= '0;
            out_r        <= '0;
            out_valid    <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state      <= state_nx;
            active_sel <= active_nx;
            level      <= level_nx;
            head       <= head + AW'(pop);
            tail       <= tail + AW'(push);
            out_valid  <= frame_req;
            if (frame_req)
                {out_l, out_r} <= pop ? mem[head] : 32'd0;
            if (underrun && underrun_cnt != '1)
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk_74a) begin
        if (push)
            mem[tail] <= act_data;
    end
endmodule

// File: tb/tb_audio_sample_sched.sv
// tb_audio_sample_sched: directed scoreboard bench for audio_sample_sched
module tb_audio_sample_sched;
    logic clk_74a = 1'b0, reset_n = 1'b0;
    logic src0_valid = 1'b0, src1_valid = 1'b0, src_sel = 1'b0, frame_req = 1'b0;
    logic [15:0] src0_l = '0, src0_r = '0, src1_l = '0, src1_r = '0;
    logic src0_ready, src1_ready, out_valid, active_sel;
    logic [15:0] out_l, out_r;
    logic [3:0] level;
    logic [7:0] underrun_cnt;
    logic [31:0] q [$];
    int errors = 0, checks = 0;

    audio_sample_sched dut (
        .clk_74a(clk_74a), .reset_n(reset_n),
        .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_l(src0_l), .src0_r(src0_r),
        .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_l(src1_l), .src1_r(src1_r),
        .src_sel(src_sel), .frame_req(frame_req), .out_l(out_l), .out_r(out_r),
        .out_valid(out_valid), .level(level), .active_sel(active_sel), .underrun_cnt(underrun_cnt)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_74a) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_frame: got unexpected %h%h expected no output", out_l, out_r);
            end else
                check("out_frame", {out_l, out_r}, q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk_74a);
        #1;
    endtask

    task automatic push(input logic src, input logic [15:0] l, input logic [15:0] r);
        if (src) begin
            src1_valid = 1'b1; src1_l = l; src1_r = r;
            #0 check("src1_ready", 32'(src1_ready), 32'd1);
            tick();
            src1_valid = 1'b0;
        end else begin
            src0_valid = 1'b1; src0_l = l; src0_r = r;
            #0 check("src0_ready", 32'(src0_ready), 32'd1);
            tick();
            src0_valid = 1'b0;
        end
    endtask

    task automatic req(input logic [31:0] exp);
        frame_req = 1'b1;
        q.push_back(exp);
        tick();
        frame_req = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        repeat (3) tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_out", {out_l, out_r}, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_cnt", 32'(underrun_cnt), 32'd0);
        check("rst_active", 32'(active_sel), 32'd0);
        check("rst_src0_ready", 32'(src0_ready), 32'd1);
        reset_n = 1'b1;
        tick();
        // inactive source is always ready and its frames are dropped
        src1_valid = 1'b1; src1_l = 16'hdead; src1_r = 16'hbeef;
        #0 check("inactive_src1_ready", 32'(src1_ready), 32'd1);
        tick();
        src1_valid = 1'b0;
        check("inactive_level", 32'(level), 32'd0);
        req(32'd0);
        check("fill_no_count", 32'(underrun_cnt), 32'd0);
        for (int i = 1; i <= 4; i++) push(1'b0, 16'(i * 16'h0101), ~16'(i * 16'h0101));
        check("prefill_level", 32'(level), 32'd4);
        tick();
        for (int i = 1; i <= 4; i++) req({16'(i * 16'h0101), ~16'(i * 16'h0101)});
        check("drained_level", 32'(level), 32'd0);
        req(32'd0);
        check("underrun_cnt1", 32'(underrun_cnt), 32'd1);
        req(32'd0);
        check("fill_req_cnt", 32'(underrun_cnt), 32'd1);
        for (int j = 0; j < 255; j++) begin
            for (int n = 0; n < 4; n++) push(1'b0, 16'(j * 4 + n), 16'(j * 4 + n) ^ 16'h5a5a);
            tick();
            for (int n = 0; n < 4; n++) req({16'(j * 4 + n), 16'(j * 4 + n) ^ 16'h5a5a});
            req(32'd0);
        end
        check("underrun_sat", 32'(underrun_cnt), 32'd255);
        for (int i = 0; i < 8; i++) push(1'b0, 16'h1000 + 16'(i), 16'h8000 + 16'(i));
        check("full_level", 32'(level), 32'd8);
        check("full_src0_ready", 32'(src0_ready), 32'd0);
        req({16'h1000, 16'h8000});
        check("pop_level", 32'(level), 32'd7);
        src0_valid = 1'b1; src0_l = 16'h1008; src0_r = 16'h8008;
        frame_req = 1'b1;
        q.push_back({16'h1001, 16'h8001});
        tick();
        src0_valid = 1'b0; frame_req = 1'b0;
        check("push_pop_level", 32'(level), 32'd7);
        for (int i = 2; i <= 5; i++) req({16'h1000 + 16'(i), 16'h8000 + 16'(i)});
        check("pre_switch_level", 32'(level), 32'd3);
        src_sel = 1'b1;
        tick();
        check("drain_src0_ready", 32'(src0_ready), 32'd0);
        check("drain_src1_ready", 32'(src1_ready), 32'd1);
        check("drain_active", 32'(active_sel), 32'd0);
        for (int i = 6; i <= 8; i++) req({16'h1000 + 16'(i), 16'h8000 + 16'(i)});
        check("switched_active", 32'(active_sel), 32'd1);
        check("switched_level", 32'(level), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            d = 16'h2000 + 16'(i);
            push(1'b1, d, ~d);
        end
        check("src1_fill_level", 32'(level), 32'd4);
        check("src0_inactive_ready", 32'(src0_ready), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            d = 16'h2000 + 16'(i);
            req({d, ~d});
        end
        for (int i = 0; i < 5; i++) push(1'b1, 16'h3000 + 16'(i), 16'h4000 + 16'(i));
        tick();
        check("pre_reset_level", 32'(level), 32'd5);
        src_sel = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_out", {out_l, out_r}, 32'd0);
        check("async_rst_cnt", 32'(underrun_cnt), 32'd0);
        check("async_rst_active", 32'(active_sel), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        req(32'd0);
        check("post_rst_cnt", 32'(underrun_cnt), 32'd0);
        check("post_rst_level", 32'(level), 32'd0);
        repeat (3) tick();
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
